// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store over a req/ready bus with MEM/WB register; MEM_TIMEOUT_EN adds a bus watchdog
module mem_access_unit #(
  parameter int word    = 32,
  parameter int rwidth  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  input  logic              MEM_MemtoReg,
  input  logic              MEM_RegWrite,
  input  logic [word-1:0]   MEM_ALU_result,
  input  logic [word-1:0]   MEM_MUX6_out,
  input  logic [rwidth-1:0] MEM_MUX8_out,
  output logic              Dmem_req,
  output logic              Dmem_we,
  output logic [word-1:0]   Dmem_addr,
  output logic [word-1:0]   Dmem_wdata,
  input  logic              Dmem_ready,
  input  logic [word-1:0]   Dmem_rdata,
  output logic              Mem_stall,
  output logic              Mem_addr_err,
  output logic              Mem_bus_err,
  output logic              WB_RegWrite,
  output logic              WB_MemtoReg,
  output logic [word-1:0]   WB_ReadData,
  output logic [word-1:0]   WB_ALU_result,
  output logic [rwidth-1:0] WB_MUX8_out
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic req_q, req_d, we_q, we_d, aerr_q, aerr_d, berr_q, berr_d;
  logic [word-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic rw_q, rw_d, m2r_q, m2r_d;
  logic [word-1:0] rd_q, rd_d, alu_q, alu_d;
  logic [rwidth-1:0] dst_q, dst_d;
  logic access, aligned, timeout, stall;
  assign access  = MEM_MemRead | MEM_MemWrite;
  assign aligned = MEM_ALU_result[1:0] == 2'b00;
`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q;
  always_ff @(posedge Clock)
    if (Reset || state_q == IDLE) cnt_q <= '0;
    else if (!Dmem_ready) cnt_q <= cnt_q + 8'd1;
  assign timeout = state_q == WAIT && cnt_q == 8'(TIMEOUT - 1);
`else
  assign timeout = TIMEOUT < 1;
`endif
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    aerr_d  = 1'b0;
    berr_d  = 1'b0;
    rw_d    = MEM_RegWrite;
    m2r_d   = MEM_MemtoReg;
    rd_d    = '0;
    alu_d   = MEM_ALU_result;
    dst_d   = MEM_MUX8_out;
    stall   = 1'b0;
    if (state_q == IDLE) begin
      if (access) begin
        rw_d  = 1'b0;
        m2r_d = 1'b0;
        if (aligned) begin
          stall   = 1'b1;
          req_d   = 1'b1;
          we_d    = !MEM_MemRead;
          addr_d  = MEM_ALU_result;
          wdata_d = MEM_MUX6_out;
          state_d = WAIT;
        end else aerr_d = 1'b1;
      end
    end else if (Dmem_ready) begin
      req_d   = 1'b0;
      we_d    = 1'b0;
      rd_d    = MEM_MemRead ? Dmem_rdata : '0;
      state_d = IDLE;
    end else begin
      rw_d  = 1'b0;
      m2r_d = 1'b0;
      if (timeout) begin
        req_d   = 1'b0;
        we_d    = 1'b0;
        berr_d  = 1'b1;
        state_d = IDLE;
      end else stall = 1'b1;
    end
  end
  always_ff @(posedge Clock)
    if (Reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      aerr_q  <= 1'b0;
      berr_q  <= 1'b0;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      rd_q    <= '0;
      alu_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      aerr_q  <= aerr_d;
      berr_q  <= berr_d;
      rw_q    <= rw_d;
      m2r_q   <= m2r_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      dst_q   <= dst_d;
    end
  assign Mem_stall     = stall & !Reset;
  assign Dmem_req      = req_q;
  assign Dmem_we       = we_q;
  assign Dmem_addr     = addr_q;
  assign Dmem_wdata    = wdata_q;
  assign Mem_addr_err  = aerr_q;
  assign Mem_bus_err   = berr_q;
  assign WB_RegWrite   = rw_q;
  assign WB_MemtoReg   = m2r_q;
  assign WB_ReadData   = rd_q;
  assign WB_ALU_result = alu_q;
  assign WB_MUX8_out   = dst_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
  logic clk = 1'b0, rst;
  logic rd, wr, m2r, rw, ready;
  logic [31:0] alu, sdata, rdata;
  logic [4:0] dst;
  logic req, we, stall, aerr, berr, wb_rw, wb_m2r;
  logic [31:0] addr, wdata, wb_rd, wb_alu;
  logic [4:0] wb_dst;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  mem_access_unit #(.word(32), .rwidth(5), .TIMEOUT(4)) dut (
    .Clock(clk), .Reset(rst),
    .MEM_MemRead(rd), .MEM_MemWrite(wr), .MEM_MemtoReg(m2r), .MEM_RegWrite(rw),
    .MEM_ALU_result(alu), .MEM_MUX6_out(sdata), .MEM_MUX8_out(dst),
    .Dmem_req(req), .Dmem_we(we), .Dmem_addr(addr), .Dmem_wdata(wdata),
    .Dmem_ready(ready), .Dmem_rdata(rdata),
    .Mem_stall(stall), .Mem_addr_err(aerr), .Mem_bus_err(berr),
    .WB_RegWrite(wb_rw), .WB_MemtoReg(wb_m2r), .WB_ReadData(wb_rd),
    .WB_ALU_result(wb_alu), .WB_MUX8_out(wb_dst)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle_in();
    {rd, wr, m2r, rw, ready} = '0;
    alu = '0; sdata = '0; dst = '0; rdata = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int n, input logic [31:0] rdat, input string tag);
    int ns = 0, nr = 0;
    rd = r; wr = w; m2r = r; rw = r; alu = a; sdata = d; dst = 5'd9;
    for (int c = 0; c <= n + 1; c++) begin
      ready = (c == n + 1);
      rdata = ready ? rdat : 32'h0;
      #1;
      if (stall) ns++;
      if (req) nr++;
      if (c == n + 1) begin
        chk({tag, "_addr"}, addr, a);
        chk({tag, "_we"}, {31'd0, we}, {31'd0, !r});
        if (w && !r) chk({tag, "_wdata"}, wdata, d);
      end
      tick();
    end
    idle_in();
    #1;
    chk({tag, "_stall_cycles"}, ns, n + 1);
    chk({tag, "_req_cycles"}, nr, n + 1);
    chk({tag, "_req_drop"}, {31'd0, req}, 32'd0);
    chk({tag, "_wb_rw"}, {31'd0, wb_rw}, {31'd0, r});
    chk({tag, "_wb_rdata"}, wb_rd, r ? rdat : 32'h0);
  endtask
  initial begin
    rst = 1'b1;
    rd = 1'($urandom); wr = 1'($urandom); m2r = 1'($urandom); rw = 1'($urandom);
    ready = 1'($urandom); alu = $urandom; sdata = $urandom; rdata = $urandom; dst = 5'($urandom);
    tick(); tick();
    chk("rst_outs", {req, we, aerr, berr, wb_rw, wb_m2r, stall}, 32'd0);
    chk("rst_bus", addr | wdata, 32'd0);
    chk("rst_wb", wb_rd | wb_alu | {27'd0, wb_dst}, 32'd0);
    idle_in();
    rst = 1'b0;
    tick();
    rw = 1'b1; alu = 32'h0000_1234; dst = 5'd5;
    #1 chk("pt_stall", {31'd0, stall}, 32'd0);
    tick();
    idle_in();
    #1;
    chk("pt_wb_rw", {31'd0, wb_rw}, 32'd1);
    chk("pt_wb_alu", wb_alu, 32'h1234);
    chk("pt_wb_dst", {27'd0, wb_dst}, 32'd5);
    chk("pt_wb_rd", wb_rd, 32'd0);
    chk("pt_stall2", {31'd0, stall}, 32'd0);
    tick();
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 2, 32'hDEAD_BEEF, "ld");
    chk("ld_wb_m2r", {31'd0, wb_m2r}, 32'd1);
    tick();
    chk("ld_wb_once", {31'd0, wb_rw}, 32'd0);
    chk("ld_addr_hold", addr, 32'h40);
    do_access(1'b0, 1'b1, 32'h80, 32'hCAFE_F00D, 0, 32'h0, "st");
    chk("st_wdata_hold", wdata, 32'hCAFE_F00D);
    do_access(1'b1, 1'b0, 32'h44, 32'h0, 0, 32'h1357_9BDF, "b2b");
    tick();
    rd = 1'b1; rw = 1'b1; alu = 32'h42;
    #1;
    chk("mis_stall", {31'd0, stall}, 32'd0);
    tick();
    idle_in();
    #1;
    chk("mis_err", {31'd0, aerr}, 32'd1);
    chk("mis_req", {31'd0, req}, 32'd0);
    chk("mis_wb_rw", {31'd0, wb_rw}, 32'd0);
    tick();
    chk("mis_err_pulse", {31'd0, aerr}, 32'd0);
    rd = 1'b1; rw = 1'b1; m2r = 1'b1; alu = 32'h100;
    tick();
    chk("rw_req", {31'd0, req}, 32'd1);
    rst = 1'b1;
    ready = 1'b1; rdata = 32'h5555_AAAA;
    #1 chk("rw_stall_rst", {31'd0, stall}, 32'd0);
    tick();
    rst = 1'b0;
    idle_in();
    #1;
    chk("rw_req_drop", {31'd0, req}, 32'd0);
    chk("rw_no_wb", {31'd0, wb_rw}, 32'd0);
    chk("rw_wb_rd", wb_rd, 32'd0);
    tick();
    chk("rw_idle", {30'd0, req, stall}, 32'd0);
`ifdef MEM_TIMEOUT_EN
    begin
      int ns = 0;
      rd = 1'b1; rw = 1'b1; alu = 32'h200;
      for (int c = 0; c < 20; c++) begin
        #1;
        if (!stall) break;
        ns++;
        tick();
      end
      chk("to_stall_cycles", ns, 32'd4);
      tick();
      idle_in();
      #1;
      chk("to_bus_err", {31'd0, berr}, 32'd1);
      chk("to_req_drop", {31'd0, req}, 32'd0);
      chk("to_wb_rw", {31'd0, wb_rw}, 32'd0);
      tick();
      chk("to_err_pulse", {31'd0, berr}, 32'd0);
      rw = 1'b1; alu = 32'h77; dst = 5'd3;
      #1 chk("to_idle_stall", {31'd0, stall}, 32'd0);
      tick();
      idle_in();
      #1 chk("to_idle_wb", wb_alu, 32'h77);
    end
`else
    chk("bus_err_tied", {31'd0, berr}, 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
